// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer: queues {j,k} commands, pulses them into a jk_latch and
// checks q/q_n after a settle window.
// Ports: ck/rst_n; cmd_valid/cmd/cmd_ready push side; j/k drive; q/q_n sense;
// busy, sticky err, saturating err_count, wrapping done_count.
module jk_drive_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             q_n,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_e;

  state_e           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       cmd_q, cmd_d;
  logic             q0_q, q0_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic empty, full, push, pop, exp_q;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push  = cmd_valid && !full;
    pop   = (state_q == S_IDLE) && !empty;

    case (cmd_q)
      2'b00:   exp_q = q0_q;
      2'b01:   exp_q = 1'b0;
      2'b10:   exp_q = 1'b1;
      default: exp_q = ~q0_q;
    endcase

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    cmd_d      = cmd_q;
    q0_d       = q0_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    done_cnt_d = done_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d    = S_DRIVE;
          cmd_d      = mem_q[rd_ptr_q[AW-1:0]];
          q0_d       = q;
          {j_d, k_d} = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
        cnt_d   = SW'(SETTLE - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        state_d    = S_IDLE;
        done_cnt_d = done_cnt_q + CNT_W'(1);
        // An X/Z on q or q_n makes the condition unknown and lands in
        // the failing branch.
        if ((q == exp_q) && (q_n != q)) begin
          err_d = err_q;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_q      <= 2'b00;
      q0_q       <= 1'b0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmd_q      <= cmd_d;
      q0_q       <= q0_d;
      j_q        <= j_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge ck) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd;
  end

  assign cmd_ready  = !full;
  assign j          = j_q;
  assign k          = k_q;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign err        = err_q;
  assign err_count  = err_cnt_q;
  assign done_count = done_cnt_q;

endmodule
